compare_bank: RTL and testbench
===============================

Name: compare_bank

Overview:
- Parametrised, N-channel successor to the two-register equality comparator.
- Each channel holds two operand registers (A, B), loaded independently from shared data buses, and produces a registered relational result under a global compare mode.
- Adds per-channel masking, operand-valid tracking, aggregate match flags, a saturating hit counter and a sticky miss flag for status polling.
- Sits between the data-capture registers and control/status logic.

Parameters:
- D, 8, operand data width in bits.
- N, 4, number of compare channels.
- CW, 16, hit counter width in bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- data1  in  D  operand A bus, shared by all channels.
- data2  in  D  operand B bus, shared by all channels.
- select1  in  N  per-channel load enable for A from data1.
- select2  in  N  per-channel load enable for B from data2.
- mode  in  3  compare mode: 000 EQ, 001 NE, 010 LT unsigned, 011 GT unsigned, 100 LT signed, 101 GT signed, 110 LE unsigned, 111 GE unsigned. Result is (A op B).
- mask  in  N  channel enable; 0 excludes the channel from outputs and statistics.
- clr_stat  in  1  clears hit_cnt and sticky_miss.
- q5  out  N  per-channel result true.
- q4  out  N  per-channel result false.
- all_match  out  1  every valid, unmasked channel is true, and at least one such channel exists.
- any_match  out  1  any bit of q5 is set.
- hit_cnt  out  CW  saturating count of true evaluation events.
- sticky_miss  out  1  set by any false evaluation event; held until cleared.

Behaviour:
- Reset (reset=0 at a clock edge): clears A_i, B_i, loaded flags, result register, pending flags, hit_cnt and sticky_miss. All outputs read 0 the cycle after.
- Reset mid-operation discards all in-flight loads and pending events.
- Operand load:
  - select1[i]=1 at edge k loads A_i<=data1 and sets loadedA_i.
  - select2[i]=1 likewise loads B_i and sets loadedB_i.
  - Both may load in the same cycle.
  - A channel is valid_i = loadedA_i & loadedB_i; valid clears only on reset.
- Compare:
  - res_i is registered every cycle from the current A_i, B_i and mode, so latency is one cycle from operand register to res.
  - Operands loaded at edge k produce res at edge k+1.
  - Signed modes use two's-complement interpretation of D bits; other modes are unsigned.
- Outputs:
  - q5[i] = res_i & valid_i & mask[i].
  - q4[i] = ~res_i & valid_i & mask[i].
  - q4 and q5 are never both 1; both are 0 for invalid or masked channels.
  - all_match and any_match are combinational from q5, q4, valid and mask.
- Evaluation event:
  - pend_i is set at edge k when any load occurs on channel i.
  - At edge k+1, res_i reflects the new operands. If pend_i & valid_i & mask[i], the channel generates one event, and pend_i clears at that edge.
  - Mode or mask changes alone re-evaluate res but generate no event.
  - Back-to-back loads generate one event per load cycle.
- Statistics:
  - At each edge, hit_cnt += (number of channels with event and res true).
  - Multiple channels in one cycle add their popcount.
  - Saturates at 2^CW-1; never wraps.
  - sticky_miss <= 1 if any event has res false.
- clr_stat=1 at an edge: hit_cnt <= 0 and sticky_miss <= 0. Events in that same cycle are dropped; clear wins.
- reset has priority over clr_stat and loads.

Test Plan:
- Reset, then load ch0 with A=0x5A, B=0x5A in the same cycle, mode=EQ, mask=0001 → one cycle later q5=0001, q4=0000, all_match=1, hit_cnt=1, sticky_miss=0.
- Load ch1 A=0x80, B=0x01, mask=0010:
  - mode=011 (GT unsigned) → q5[1]=1.
  - Switch to mode=101 (GT signed), no load → q4[1]=1 next cycle; hit_cnt and sticky_miss unchanged.
- Load only A on ch2 (B never loaded) → q4[2]=q5[2]=0, no event, hit_cnt unchanged. Then load B → valid, event counted.
- CW=2, repeatedly reload ch0 with equal operands 5 times → hit_cnt reaches 3 and holds at 3.
- Load ch0 with mismatching operands → sticky_miss=1. Later matching loads keep it set; assert clr_stat in the same cycle as a ch0 event → hit_cnt=0, sticky_miss=0, event dropped.
- Assert reset=0 one cycle after loading all 4 channels (events pending) → all outputs 0, hit_cnt=0, no event counted after release.

Source files
------------

// File: rtl/compare_bank.sv
// N-channel relational comparator bank: per-channel operand registers, a registered
// compare result, a valid/mask output qualifier, aggregate match flags and event statistics.
module compare_bank #(
    parameter int D  = 8,
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [D-1:0]  data1,
    input  logic [D-1:0]  data2,
    input  logic [N-1:0]  select1,
    input  logic [N-1:0]  select2,
    input  logic [2:0]    mode,
    input  logic [N-1:0]  mask,
    input  logic          clr_stat,
    output logic [N-1:0]  q5,
    output logic [N-1:0]  q4,
    output logic          all_match,
    output logic          any_match,
    output logic [CW-1:0] hit_cnt,
    output logic          sticky_miss
);

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LTU = 3'b010,
        CMP_GTU = 3'b011,
        CMP_LTS = 3'b100,
        CMP_GTS = 3'b101,
        CMP_LEU = 3'b110,
        CMP_GEU = 3'b111
    } mode_e;

    localparam int PW = $clog2(N + 1);
    localparam int SW = ((CW > PW) ? CW : PW) + 1;

    logic [D-1:0]  a_reg [N];
    logic [D-1:0]  b_reg [N];
    logic [N-1:0]  loaded_a;
    logic [N-1:0]  loaded_b;
    logic [N-1:0]  res;
    logic [N-1:0]  pend;

    logic [N-1:0]  valid;
    logic [N-1:0]  live;
    logic [N-1:0]  res_next;
    logic [N-1:0]  evt;
    logic [N-1:0]  evt_hit;
    logic          evt_miss;
    logic [PW-1:0] hit_pop;
    logic [SW-1:0] hit_sum;
    logic [CW-1:0] hit_next;
    mode_e         mode_c;

    assign mode_c = mode_e'(mode);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        res_next = '0;
        for (int i = 0; i < N; i++) begin
            case (mode_c)
                CMP_EQ:  res_next[i] = (a_reg[i] == b_reg[i]);
                CMP_NE:  res_next[i] = (a_reg[i] != b_reg[i]);
                CMP_LTU: res_next[i] = (a_reg[i] <  b_reg[i]);
                CMP_GTU: res_next[i] = (a_reg[i] >  b_reg[i]);
                CMP_LTS: res_next[i] = ($signed(a_reg[i]) < $signed(b_reg[i]));
                CMP_GTS: res_next[i] = ($signed(a_reg[i]) > $signed(b_reg[i]));
                CMP_LEU: res_next[i] = (a_reg[i] <= b_reg[i]);
                CMP_GEU: res_next[i] = (a_reg[i] >= b_reg[i]);
                default: res_next[i] = 1'b0;
            endcase
        end
    end

    // An event is the first evaluation after a load, scored on the freshly computed result.
    assign valid    = loaded_a & loaded_b;
    assign live     = valid & mask;
    assign evt      = pend & live;
    assign evt_hit  = evt & res_next;
    assign evt_miss = |(evt & ~res_next);

    always_comb begin
        hit_pop = '0;
        for (int i = 0; i < N; i++) begin
            hit_pop = hit_pop + PW'(evt_hit[i]);
        end
    end

    assign hit_sum  = SW'(hit_cnt) + SW'(hit_pop);
    assign hit_next = (hit_sum > SW'({CW{1'b1}})) ? {CW{1'b1}} : hit_sum[CW-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: operand storage is reset too, so no stale operand can surface after reset.
            for (int i = 0; i < N; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
            loaded_a    <= '0;
            loaded_b    <= '0;
            res         <= '0;
            pend        <= '0;
            hit_cnt     <= '0;
            sticky_miss <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            for (int i = 0; i < N; i++) begin
                if (select1[i]) begin
                    a_reg[i]    <= data1;
                    loaded_a[i] <= 1'b1;
                end
                if (select2[i]) begin
                    b_reg[i]    <= data2;
                    loaded_b[i] <= 1'b1;
                end
            end
            res  <= res_next;
            // Pending lasts exactly one evaluation, so mode/mask changes later never score.
            pend <= select1 | select2;
            if (clr_stat) begin
                hit_cnt     <= '0;
                sticky_miss <= 1'b0;
            end else begin
                hit_cnt <= hit_next;
                if (evt_miss) begin
                    sticky_miss <= 1'b1;
                end
            end
        end
    end

    assign q5        = res & live;
    assign q4        = ~res & live;
    assign any_match = |q5;
    assign all_match = (|live) && (q5 == live);

endmodule

// File: tb/tb_compare_bank.sv
// Directed bench for compare_bank: a default instance plus a CW=2 instance for saturation,
// both driven from the same stimulus.
module tb_compare_bank;

    localparam int D = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [D-1:0] data1, data2;
    logic [N-1:0] select1, select2;
    logic [2:0]   mode;
    logic [N-1:0] mask;
    logic         clr_stat;

    logic [N-1:0] q5, q4, q5_s, q4_s;
    logic         all_match, any_match, all_s, any_s;
    logic [15:0]  hit_cnt;
    logic [1:0]   hit_s;
    logic         sticky_miss, sticky_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    compare_bank #(.D(D), .N(N), .CW(16)) dut (
        .clk(clk), .reset(reset), .data1(data1), .data2(data2),
        .select1(select1), .select2(select2), .mode(mode), .mask(mask),
        .clr_stat(clr_stat), .q5(q5), .q4(q4), .all_match(all_match),
        .any_match(any_match), .hit_cnt(hit_cnt), .sticky_miss(sticky_miss)
    );

    compare_bank #(.D(D), .N(N), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .data1(data1), .data2(data2),
        .select1(select1), .select2(select2), .mode(mode), .mask(mask),
        .clr_stat(clr_stat), .q5(q5_s), .q4(q4_s), .all_match(all_s),
        .any_match(any_s), .hit_cnt(hit_s), .sticky_miss(sticky_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load operands on the given channels at one edge, then let the event edge pass.
    task automatic load(input logic [N-1:0] s1, input logic [N-1:0] s2,
                        input logic [D-1:0] d1, input logic [D-1:0] d2);
        select1 = s1;
        select2 = s2;
        data1   = d1;
        data2   = d2;
        tick();
        select1 = '0;
        select2 = '0;
        tick();
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] e5, input logic [N-1:0] e4,
                           input logic eall, input logic eany, input logic [15:0] ehit,
                           input logic esticky);
        chk({tag, ".q5"}, 32'(q5), 32'(e5));
        chk({tag, ".q4"}, 32'(q4), 32'(e4));
        chk({tag, ".all"}, 32'(all_match), 32'(eall));
        chk({tag, ".any"}, 32'(any_match), 32'(eany));
        chk({tag, ".hit"}, 32'(hit_cnt), 32'(ehit));
        chk({tag, ".sticky"}, 32'(sticky_miss), 32'(esticky));
    endtask

    initial begin
        reset = 1'b0; data1 = '0; data2 = '0; select1 = '0; select2 = '0;
        mode = 3'b000; mask = '0; clr_stat = 1'b0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd0, 1'b0);
        reset = 1'b1;

        // ch0 equal operands under EQ
        mask = 4'b0001;
        mode = 3'b000;
        load(4'b0001, 4'b0001, 8'h5A, 8'h5A);
        chk_out("eq_ch0", 4'b0001, 4'b0000, 1'b1, 1'b1, 16'd1, 1'b0);

        // ch1 0x80 vs 0x01: GT unsigned true, GT signed false
        mask = 4'b0010;
        mode = 3'b011;
        load(4'b0010, 4'b0010, 8'h80, 8'h01);
        chk_out("gtu_ch1", 4'b0010, 4'b0000, 1'b1, 1'b1, 16'd2, 1'b0);
        mode = 3'b101;
        tick();
        chk_out("gts_ch1", 4'b0000, 4'b0010, 1'b0, 1'b0, 16'd2, 1'b0);
        mode = 3'b010; tick(); chk("ltu_ch1", 32'(q5), 32'h0);
        mode = 3'b100; tick(); chk("lts_ch1", 32'(q5), 32'h2);
        mode = 3'b110; tick(); chk("leu_ch1", 32'(q5), 32'h0);
        mode = 3'b111; tick(); chk("geu_ch1", 32'(q5), 32'h2);
        mode = 3'b001; tick(); chk("ne_ch1", 32'(q5), 32'h2);
        chk("mode_no_evt", 32'(hit_cnt), 32'd2);

        // ch2: A only leaves the channel invalid, then B completes it
        mask = 4'b0100;
        mode = 3'b000;
        load(4'b0100, 4'b0000, 8'h33, 8'h00);
        chk_out("ch2_a_only", 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd2, 1'b0);
        load(4'b0000, 4'b0100, 8'h00, 8'h33);
        chk_out("ch2_b_load", 4'b0100, 4'b0000, 1'b1, 1'b1, 16'd3, 1'b0);

        // sticky miss, then a later match keeps it set
        mask = 4'b0001;
        load(4'b0001, 4'b0001, 8'h11, 8'h22);
        chk_out("miss_ch0", 4'b0000, 4'b0001, 1'b0, 1'b0, 16'd3, 1'b1);
        load(4'b0001, 4'b0001, 8'h44, 8'h44);
        chk_out("match_after_miss", 4'b0001, 4'b0000, 1'b1, 1'b1, 16'd4, 1'b1);

        // clr_stat coincides with a ch0 event: clear wins, event dropped for good
        select1 = 4'b0001; select2 = 4'b0001; data1 = 8'h66; data2 = 8'h66;
        tick();
        select1 = '0; select2 = '0; clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk_out("clr_vs_evt", 4'b0001, 4'b0000, 1'b1, 1'b1, 16'd0, 1'b0);
        tick();
        chk("clr_dropped", 32'(hit_cnt), 32'd0);

        // two hits in one cycle add their popcount
        mask = 4'b1111;
        load(4'b1001, 4'b1001, 8'h09, 8'h09);
        chk_out("popcount", 4'b1101, 4'b0010, 1'b0, 1'b1, 16'd2, 1'b0);

        // reset while all four channels have pending events
        select1 = 4'b1111; select2 = 4'b1111; data1 = 8'h07; data2 = 8'h07;
        tick();
        select1 = '0; select2 = '0; reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_out("reset_pend", 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd0, 1'b0);
        tick();
        chk_out("after_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd0, 1'b0);

        // CW=2 saturates at 3 while CW=16 keeps counting
        mask = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            load(4'b0001, 4'b0001, 8'hAA, 8'hAA);
            chk($sformatf("sat_small_%0d", k), 32'(hit_s), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("sat_wide_%0d", k), 32'(hit_cnt), 32'(k));
        end

        // back-to-back loads score one event per load cycle
        select1 = 4'b0001; select2 = 4'b0001;
        tick();
        tick();
        tick();
        select1 = '0; select2 = '0;
        tick();
        chk("b2b_wide", 32'(hit_cnt), 32'd8);
        chk("b2b_small", 32'(hit_s), 32'd3);
        chk("b2b_sticky", 32'(sticky_s), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
